// File: rtl/vga_pkg.sv
// Shared constants for the VGA pattern generator: channel width, pattern
// codes, colour-bar table and the per-axis box state.
package vga_pkg;

  localparam int CHAN_W = 8;

  typedef enum logic [2:0] {
    PAT_BLACK = 3'd0,
    PAT_BARS  = 3'd1,
    PAT_CHECK = 3'd2,
    PAT_GRAD  = 3'd3,
    PAT_BOX   = 3'd4
  } pat_e;

  typedef struct packed {
    logic [CHAN_W-1:0] r;
    logic [CHAN_W-1:0] g;
    logic [CHAN_W-1:0] b;
  } rgb_t;

  // Bar colours, index 0 (leftmost) .. 7 (rightmost); element 0 is the LSB slice.
  localparam logic [7:0][3*CHAN_W-1:0] BAR_TABLE = {
    24'h000000,  // 7 black
    24'h0000FF,  // 6 blue
    24'hFF0000,  // 5 red
    24'hFF00FF,  // 4 magenta
    24'h00FF00,  // 3 green
    24'h00FFFF,  // 2 cyan
    24'hFFFF00,  // 1 yellow
    24'hFFFFFF   // 0 white
  };

  // One axis of the bouncing box: position and direction (1 = increasing).
  typedef struct packed {
    logic [11:0] pos;
    logic        dir;
  } axis_t;

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position tracker; both axes advance once per frame start.
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int BOX_SIZE = 32,
  parameter int BOX_STEP = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        frame_start,
  input  logic [11:0] h_res,
  input  logic [11:0] v_res,
  output logic [11:0] BOX_X,
  output logic [11:0] BOX_Y
);

  axis_t x_q, x_d, y_q, y_d;

  // 13-bit arithmetic so pos+size+step never wraps.
  function automatic axis_t axis_next(input axis_t cur, input logic [11:0] res);
    logic [12:0] pos13, res13;
    axis_t       nxt;
    pos13 = {1'b0, cur.pos};
    res13 = {1'b0, res};
    nxt   = cur;
    if (pos13 + 13'(BOX_SIZE) > res13) begin
      // Resolution shrank under the box: restart from the origin.
      nxt.pos = '0;
      nxt.dir = 1'b1;
    end else if (cur.dir && (pos13 + 13'(BOX_SIZE) + 13'(BOX_STEP) > res13)) begin
      nxt.dir = 1'b0;
      nxt.pos = (pos13 < 13'(BOX_STEP)) ? '0 : cur.pos - 12'(BOX_STEP);
    end else if (!cur.dir && (pos13 < 13'(BOX_STEP))) begin
      nxt.dir = 1'b1;
      nxt.pos = cur.pos + 12'(BOX_STEP);
    end else if (cur.dir) begin
      nxt.pos = cur.pos + 12'(BOX_STEP);
    end else begin
      nxt.pos = cur.pos - 12'(BOX_STEP);
    end
    return nxt;
  endfunction

  // Next box state: move only at frame start.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (frame_start) begin
      x_d = axis_next(x_q, h_res);
      y_d = axis_next(y_q, v_res);
    end
  end

  // Box state registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      x_q <= '{pos: 12'd0, dir: 1'b1};
      y_q <= '{pos: 12'd0, dir: 1'b1};
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign BOX_X = x_q.pos;
  assign BOX_Y = y_q.pos;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator: colour bars, checkerboard, gradient and bouncing
// box, one registered pixel stage behind the timing generator.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int BOX_SIZE = 32,
  parameter int BOX_STEP = 2,
  parameter int CHK_LOG2 = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [2:0]        PAT_SEL,
  input  logic [11:0]       H_RES,
  input  logic [11:0]       V_RES,
  input  logic              DISP_ACTIVE,
  input  logic              VSYNC,
  input  logic [11:0]       XPOS,
  input  logic [11:0]       YPOS,
  output logic [CHAN_W-1:0] R,
  output logic [CHAN_W-1:0] G,
  output logic [CHAN_W-1:0] B,
  output logic              DE_OUT,
  output logic [15:0]       FRAME_CNT
);

  logic        vsync_q, vsync_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [2:0]  pat_q, pat_d;
  rgb_t        rgb_q, rgb_d;
  logic        de_q, de_d;
  logic        frame_start;
  logic [11:0] box_x, box_y;

  assign frame_start = VSYNC & ~vsync_q;

  vga_box_mover #(
    .BOX_SIZE(BOX_SIZE),
    .BOX_STEP(BOX_STEP)
  ) u_box (
    .CLK        (CLK),
    .RST        (RST),
    .frame_start(frame_start),
    .h_res      (H_RES),
    .v_res      (V_RES),
    .BOX_X      (box_x),
    .BOX_Y      (box_y)
  );

  // Frame bookkeeping: pattern and counter change only at frame start.
  always_comb begin
    vsync_d     = VSYNC;
    frame_cnt_d = frame_cnt_q;
    pat_d       = pat_q;
    if (frame_start) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      pat_d       = PAT_SEL;
    end
  end

  // Pixel colour for the current coordinate, blanked outside active video.
  always_comb begin
    logic [11:0] bar_w;
    logic [2:0]  bar_idx;
    logic        in_box;
    rgb_t        pix;
    bar_w   = H_RES >> 3;
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if ({3'b000, XPOS} >= 15'(k) * {3'b000, bar_w}) bar_idx = 3'(k);
    end
    in_box = (XPOS >= box_x) && ({1'b0, XPOS} < {1'b0, box_x} + 13'(BOX_SIZE)) &&
             (YPOS >= box_y) && ({1'b0, YPOS} < {1'b0, box_y} + 13'(BOX_SIZE));
    pix = '0;
    case (pat_q)
      PAT_BARS:  pix = BAR_TABLE[bar_idx];
      PAT_CHECK: pix = (XPOS[CHK_LOG2] ^ YPOS[CHK_LOG2]) ? 24'hFFFFFF : 24'h000000;
      PAT_GRAD:  pix = '{r: XPOS[7:0], g: YPOS[7:0], b: frame_cnt_q[7:0]};
      PAT_BOX:   pix = in_box ? 24'hFFFFFF : 24'h0000FF;
      default:   pix = '0;
    endcase
    rgb_d = DISP_ACTIVE ? pix : '0;
    de_d  = DISP_ACTIVE;
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vsync_q     <= 1'b0;
      frame_cnt_q <= '0;
      pat_q       <= PAT_BLACK;
      rgb_q       <= '0;
      de_q        <= 1'b0;
    end else begin
      vsync_q     <= vsync_d;
      frame_cnt_q <= frame_cnt_d;
      pat_q       <= pat_d;
      rgb_q       <= rgb_d;
      de_q        <= de_d;
    end
  end

  assign R         = rgb_q.r;
  assign G         = rgb_q.g;
  assign B         = rgb_q.b;
  assign DE_OUT    = de_q;
  assign FRAME_CNT = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen.
module tb_vga_pattern_gen;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  PAT_SEL;
  logic [11:0] H_RES, V_RES, XPOS, YPOS;
  logic        DISP_ACTIVE, VSYNC;
  logic [7:0]  R, G, B;
  logic        DE_OUT;
  logic [15:0] FRAME_CNT;

  int checks = 0;
  int errors = 0;

  // Reference state: frame counter and box position/direction.
  logic [15:0] m_fc;
  logic [11:0] m_bx, m_by;
  logic        m_dx, m_dy;

  vga_pattern_gen dut (
    .CLK(CLK), .RST(RST), .PAT_SEL(PAT_SEL), .H_RES(H_RES), .V_RES(V_RES),
    .DISP_ACTIVE(DISP_ACTIVE), .VSYNC(VSYNC), .XPOS(XPOS), .YPOS(YPOS),
    .R(R), .G(G), .B(B), .DE_OUT(DE_OUT), .FRAME_CNT(FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_fc = 16'd0; m_bx = 12'd0; m_by = 12'd0; m_dx = 1'b1; m_dy = 1'b1;
  endtask

  // One axis of box motion, written from the behavioural description.
  task automatic model_axis(inout logic [11:0] p, inout logic d, input logic [11:0] res);
    int ip, ir;
    ip = int'(p); ir = int'(res);
    if (ip + 32 > ir) begin
      ip = 0; d = 1'b1;
    end else if (d && ip + 34 > ir) begin
      d = 1'b0; ip = (ip < 2) ? 0 : ip - 2;
    end else if (!d && ip < 2) begin
      d = 1'b1; ip = ip + 2;
    end else begin
      ip = d ? ip + 2 : ip - 2;
    end
    p = 12'(ip);
  endtask

  // One VSYNC rising edge (one frame start), model advanced alongside.
  task automatic pulse_vsync();
    @(negedge CLK) VSYNC = 1'b1;
    @(negedge CLK) VSYNC = 1'b0;
    m_fc = m_fc + 16'd1;
    model_axis(m_bx, m_dx, H_RES);
    model_axis(m_by, m_dy, V_RES);
  endtask

  task automatic set_pix(input logic [11:0] x, input logic [11:0] y, input logic da);
    @(negedge CLK);
    XPOS = x; YPOS = y; DISP_ACTIVE = da;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1; PAT_SEL = 3'd0; H_RES = 12'd640; V_RES = 12'd480;
    DISP_ACTIVE = 1'b1; VSYNC = 1'b0; XPOS = 12'd5; YPOS = 12'd5;
    model_reset();
    repeat (3) @(negedge CLK);
    checks++;
    if ({R, G, B, DE_OUT, FRAME_CNT} !== 41'd0) begin
      errors++;
      $display("FAIL reset_outputs: rgb=%h de=%b fc=%h, want 0", {R, G, B}, DE_OUT, FRAME_CNT);
    end
    checks++;
    if ({dut.u_box.BOX_X, dut.u_box.BOX_Y} !== 24'd0) begin
      errors++;
      $display("FAIL reset_box: x=%0d y=%0d, want 0 0", dut.u_box.BOX_X, dut.u_box.BOX_Y);
    end
    RST = 1'b0;
  endtask

  task automatic test_bars();
    logic [11:0] xs [5];
    logic [23:0] want [5];
    xs   = '{12'd0, 12'd80, 12'd559, 12'd560, 12'd639};
    want = '{24'hFFFFFF, 24'hFFFF00, 24'h0000FF, 24'h000000, 24'h000000};
    PAT_SEL = 3'd1;
    pulse_vsync();
    for (int i = 0; i < 5; i++) begin
      set_pix(xs[i], 12'd10, 1'b1);
      checks++;
      if ({R, G, B} !== want[i] || DE_OUT !== 1'b1) begin
        errors++;
        $display("FAIL bars_x%0d: rgb=%h de=%b, want %h de=1", xs[i], {R, G, B}, DE_OUT, want[i]);
      end
    end
    checks++;
    if (FRAME_CNT !== 16'd1) begin
      errors++;
      $display("FAIL first_frame: fc=%0d, want 1", FRAME_CNT);
    end
  endtask

  task automatic test_checker();
    PAT_SEL = 3'd2;
    pulse_vsync();
    set_pix(12'd32, 12'd0, 1'b1);
    checks++;
    if ({R, G, B} !== 24'hFFFFFF) begin
      errors++; $display("FAIL chk_32_0: rgb=%h, want ffffff", {R, G, B});
    end
    set_pix(12'd32, 12'd32, 1'b1);
    checks++;
    if ({R, G, B} !== 24'h000000) begin
      errors++; $display("FAIL chk_32_32: rgb=%h, want 000000", {R, G, B});
    end
    set_pix(12'd32, 12'd0, 1'b0);
    checks++;
    if ({R, G, B} !== 24'h000000 || DE_OUT !== 1'b0) begin
      errors++; $display("FAIL chk_blank: rgb=%h de=%b, want 000000 de=0", {R, G, B}, DE_OUT);
    end
  endtask

  task automatic test_pat_switch();
    PAT_SEL = 3'd3;
    pulse_vsync();
    set_pix(12'h123, 12'h045, 1'b1);
    checks++;
    if ({R, G, B} !== {8'h23, 8'h45, m_fc[7:0]}) begin
      errors++; $display("FAIL grad: rgb=%h, want %h", {R, G, B}, {8'h23, 8'h45, m_fc[7:0]});
    end
    // Mid-frame request for bars must wait for the next frame.
    PAT_SEL = 3'd1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({R, G, B} !== {8'h23, 8'h45, m_fc[7:0]}) begin
      errors++; $display("FAIL grad_hold: rgb=%h, want %h", {R, G, B}, {8'h23, 8'h45, m_fc[7:0]});
    end
    pulse_vsync();
    set_pix(12'h123, 12'h045, 1'b1);   // x=291 -> bar 3, green
    checks++;
    if ({R, G, B} !== 24'h00FF00) begin
      errors++; $display("FAIL switch_bars: rgb=%h, want 00ff00", {R, G, B});
    end
  endtask

  task automatic test_bounce();
    int max_x;
    RST = 1'b1;
    @(negedge CLK) RST = 1'b0;
    model_reset();
    PAT_SEL = 3'd4; DISP_ACTIVE = 1'b0;
    max_x = 0;
    for (int f = 1; f <= 400; f++) begin
      pulse_vsync();
      if (int'(dut.u_box.BOX_X) > max_x) max_x = int'(dut.u_box.BOX_X);
      checks++;
      if (dut.u_box.BOX_X !== m_bx || dut.u_box.BOX_Y !== m_by) begin
        errors++;
        $display("FAIL box_f%0d: x=%0d y=%0d, want %0d %0d", f, dut.u_box.BOX_X, dut.u_box.BOX_Y, m_bx, m_by);
      end
      // Turnaround points computed by hand from a 0,0 start at 2 px/frame.
      if (f == 305 || f == 306) begin
        checks++;
        if (dut.u_box.BOX_X !== ((f == 305) ? 12'd606 : 12'd604)) begin
          errors++; $display("FAIL box_xturn_f%0d: x=%0d", f, dut.u_box.BOX_X);
        end
      end
      if (f == 225 || f == 226) begin
        checks++;
        if (dut.u_box.BOX_Y !== ((f == 225) ? 12'd446 : 12'd444)) begin
          errors++; $display("FAIL box_yturn_f%0d: y=%0d", f, dut.u_box.BOX_Y);
        end
      end
    end
    checks++;
    if (max_x != 608) begin
      errors++; $display("FAIL box_xmax: max=%0d, want 608", max_x);
    end
  endtask

  task automatic test_box_pixels();
    set_pix(m_bx, m_by, 1'b1);
    checks++;
    if ({R, G, B} !== 24'hFFFFFF) begin
      errors++; $display("FAIL box_in: rgb=%h, want ffffff", {R, G, B});
    end
    set_pix(m_bx + 12'd31, m_by + 12'd31, 1'b1);
    checks++;
    if ({R, G, B} !== 24'hFFFFFF) begin
      errors++; $display("FAIL box_corner: rgb=%h, want ffffff", {R, G, B});
    end
    set_pix(m_bx + 12'd32, m_by, 1'b1);
    checks++;
    if ({R, G, B} !== 24'h0000FF) begin
      errors++; $display("FAIL box_out: rgb=%h, want 0000ff", {R, G, B});
    end
  endtask

  task automatic test_clamp();
    // Box is at x=416 after 400 frames; a 200-wide raster puts it outside.
    H_RES = 12'd200;
    pulse_vsync();
    checks++;
    if (dut.u_box.BOX_X !== 12'd0 || dut.u_box.BOX_Y !== 12'd94) begin
      errors++; $display("FAIL clamp: x=%0d y=%0d, want 0 94", dut.u_box.BOX_X, dut.u_box.BOX_Y);
    end
    H_RES = 12'd640;
    pulse_vsync();
    checks++;
    if (dut.u_box.BOX_X !== 12'd2) begin
      errors++; $display("FAIL clamp_dir: x=%0d, want 2", dut.u_box.BOX_X);
    end
  endtask

  task automatic test_wrap();
    @(negedge CLK) force dut.frame_cnt_q = 16'hFFFF;
    @(negedge CLK) release dut.frame_cnt_q;
    @(negedge CLK);
    checks++;
    if (FRAME_CNT !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_preload: fc=%h, want ffff", FRAME_CNT);
    end
    pulse_vsync();
    checks++;
    if (FRAME_CNT !== 16'h0000) begin
      errors++; $display("FAIL wrap: fc=%h, want 0000", FRAME_CNT);
    end
  endtask

  task automatic test_async_reset();
    set_pix(m_bx + 12'd100, m_by, 1'b1);
    checks++;
    if ({R, G, B} !== 24'h0000FF || DE_OUT !== 1'b1) begin
      errors++; $display("FAIL pre_rst: rgb=%h de=%b, want 0000ff de=1", {R, G, B}, DE_OUT);
    end
    #2 RST = 1'b1;
    #1;   // still before the next rising edge
    checks++;
    if ({R, G, B, DE_OUT, FRAME_CNT} !== 41'd0 || dut.u_box.BOX_X !== 12'd0) begin
      errors++;
      $display("FAIL async_rst: rgb=%h de=%b fc=%h x=%0d, want 0", {R, G, B}, DE_OUT, FRAME_CNT, dut.u_box.BOX_X);
    end
    @(negedge CLK) RST = 1'b0;
    model_reset();
    pulse_vsync();
    checks++;
    if (FRAME_CNT !== 16'd1 || dut.u_box.BOX_X !== 12'd2) begin
      errors++; $display("FAIL post_rst_frame: fc=%0d x=%0d, want 1 2", FRAME_CNT, dut.u_box.BOX_X);
    end
  endtask

  initial begin
    test_reset();
    test_bars();
    test_checker();
    test_pat_switch();
    test_bounce();
    test_box_pixels();
    test_clamp();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
